muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Iterative multiply/divide unit for the MIPS datapath. It executes MULT, MULTU, DIV and DIVU over multiple cycles and owns the architectural HI/LO registers. The single-cycle ALU cannot perform these operations. The unit sits beside the ALU in EX: the control path issues a start pulse and stalls on busy, and MFHI/MFLO read the hi/lo outputs.

Parameters:
WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  issue request; accepted only in IDLE
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
a  input  WIDTH  rs operand / dividend; sampled with start
b  input  WIDTH  rt operand / divisor; sampled with start
hi_we  input  1  MTHI write strobe
lo_we  input  1  MTLO write strobe
wdata  input  WIDTH  MTHI/MTLO data
busy  output  1  high in RUN and FINISH
done  output  1  one-cycle completion pulse
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, internal accumulators=0. Assertion mid-operation discards the operation immediately. No done pulse is generated.
- FSM: IDLE -> RUN on a clock edge with start=1. RUN runs exactly WIDTH edges, one iteration per edge; the edge that completes iteration WIDTH moves to FINISH. FINISH -> IDLE on the next edge.
- Timing: start sampled at edge E0. Iterations occur on E1..E32. On E33, hi/lo are written, done=1 and state=IDLE. done returns to 0 at E34. busy=1 from E0+ through E33-.
- Start handling:
  - start while busy=1 is ignored, with no queueing.
  - start in the cycle where done=1 is accepted, because the state is already IDLE.
- Operand preparation:
  - Signed ops take absolute values at E0 and latch the result sign and remainder sign.
  - Unsigned ops use raw operands.
- MULT/MULTU: radix-2 shift-add on the unsigned magnitudes, giving a 2*WIDTH product. In FINISH the product is negated if the sign bit is set. hi = product[63:32], lo = product[31:0].
- DIV/DIVU: restoring division on the magnitudes. In FINISH:
  - lo = quotient, negated if signs differ, truncating toward zero.
  - hi = remainder, taking the sign of the dividend.
- Divide by zero (b=0): lo = all ones, hi = a (original a, unmodified) for both DIV and DIVU.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- MTHI/MTLO:
  - hi_we/lo_we update hi/lo with wdata on the edge, only while busy=0.
  - While busy=1 they are ignored.
  - hi_we together with an accepted start: the write takes effect, and the operation result later overwrites it.
- hi/lo hold their value at all other times, including throughout RUN. Readers see the old HI/LO until E33.

Optional Feature:
MULDIV_ABORT_EN
- Defined: adds input port abort (1 bit). abort=1 on an edge while busy=1 returns the FSM to IDLE and clears busy. hi/lo are unchanged and no done pulse is generated. abort in IDLE has no effect. abort and start together in IDLE means start is accepted. The port is for exception/branch flush.
- Undefined: no abort port. An operation always runs to completion.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU
  - FSM state encodings S_IDLE/S_RUN/S_FINISH
  - the counter width constant CNT_W = 6
- Sub-module muldiv_sign_fix is a combinational post-processor. It applies the negations and the divide-by-zero and overflow overrides in FINISH. The iteration datapath stays in muldiv_unit.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=7 -> after E33 hi=0xFFFFFFFF, lo=0xFFFFFFEB, done pulse one cycle, busy low at E33.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; DIVU a=100, b=7 -> lo=14, hi=2.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=0x64; DIV a=-5, b=0 -> lo=0xFFFFFFFF, hi=0xFFFFFFFB.
- Second start and hi_we asserted at E10 of a running MULT -> both ignored, result of first op only. Back-to-back start in the done cycle -> second result at E33 relative to its own start.
- rst_n pulsed low at E15 -> hi=lo=0, busy=0 immediately, no done. With MULDIV_ABORT_EN, abort at E15 -> prior hi/lo retained, busy=0 next cycle.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op and FSM encodings shared by the multiply/divide unit, its interface and bench.
package muldiv_pkg;
    localparam int CNT_W = 6;
    typedef enum logic [1:0] {OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11} op_e;
    typedef enum logic [1:0] {S_IDLE = 2'b00, S_RUN = 2'b01, S_FINISH = 2'b10} state_e;
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: issue/HI-LO bundle between the EX control path and muldiv_unit.
// MULDIV_ABORT_EN adds the abort flush input.
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) ();
    logic start;
    op_e op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic hi_we;
    logic lo_we;
    logic [WIDTH-1:0] wdata;
    logic busy;
    logic done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
`ifdef MULDIV_ABORT_EN
    logic abort;
    modport master (output start, op, a, b, hi_we, lo_we, wdata, abort, input busy, done, hi, lo);
    modport slave (input start, op, a, b, hi_we, lo_we, wdata, abort, output busy, done, hi, lo);
`else
    modport master (output start, op, a, b, hi_we, lo_we, wdata, input busy, done, hi, lo);
    modport slave (input start, op, a, b, hi_we, lo_we, wdata, output busy, done, hi, lo);
`endif
endinterface

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: turns the magnitude result into final HI/LO, applying negation,
// divide-by-zero and signed-overflow overrides.
module muldiv_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic               neg,
    input  logic               rneg,
    input  logic               div0,
    input  logic               ovf,
    input  logic [WIDTH-1:0]   a_org,
    input  logic [2*WIDTH-1:0] acc,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] quo, rem;
    always_comb begin
        prod = neg ? -acc : acc;
        quo  = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem  = rneg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        hi   = !is_div ? prod[2*WIDTH-1:WIDTH] : div0 ? a_org : ovf ? '0 : rem;
        lo   = !is_div ? prod[WIDTH-1:0] : div0 ? '1 : ovf ? {1'b1, {(WIDTH-1){1'b0}}} : quo;
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU owning HI/LO, one iteration per clock.
// MULDIV_ABORT_EN enables the abort flush input on the interface.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic     clk,
    input logic     rst_n,
    muldiv_if.slave bus
);
    localparam int W = WIDTH;
    state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, div0_q, div0_d, ovf_q, ovf_d, done_q, done_d;
    logic [W-1:0] a_org_q, a_org_d, mcand_q, mcand_d, hi_q, hi_d, lo_q, lo_d;
    logic [W-1:0] hi_res, lo_res, a_mag, b_mag;
    logic [2*W-1:0] acc_q, acc_d, step;
    logic [W:0] mul_sum, div_sh, div_diff;
    logic sgn;

    assign sgn      = ~bus.op[0];
    assign a_mag    = (sgn && bus.a[W-1]) ? -bus.a : bus.a;
    assign b_mag    = (sgn && bus.b[W-1]) ? -bus.b : bus.b;
    // acc holds {upper product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, mcand_q & {W{acc_q[0]}}};
    assign div_sh   = {acc_q[2*W-1:W], acc_q[W-1]};
    assign div_diff = div_sh - {1'b0, mcand_q};
    assign step     = !div_q ? {mul_sum, acc_q[W-1:1]} :
                      div_diff[W] ? {div_sh[W-1:0], acc_q[W-2:0], 1'b0} :
                                    {div_diff[W-1:0], acc_q[W-2:0], 1'b1};

    muldiv_sign_fix #(.WIDTH(W)) u_fix (
        .is_div(div_q), .neg(neg_q), .rneg(rneg_q), .div0(div0_q), .ovf(ovf_q),
        .a_org(a_org_q), .acc(acc_q), .hi(hi_res), .lo(lo_res)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        div0_d  = div0_q;
        ovf_d   = ovf_q;
        a_org_d = a_org_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        if (state_q == S_IDLE) begin
            hi_d = bus.hi_we ? bus.wdata : hi_q;
            lo_d = bus.lo_we ? bus.wdata : lo_q;
            if (bus.start) begin
                state_d = S_RUN;
                cnt_d   = '0;
                div_d   = bus.op[1];
                neg_d   = sgn & (bus.a[W-1] ^ bus.b[W-1]);
                rneg_d  = sgn & bus.a[W-1];
                div0_d  = bus.b == '0;
                ovf_d   = bus.op == OP_DIV && bus.a == {1'b1, {(W-1){1'b0}}} && bus.b == '1;
                a_org_d = bus.a;
                mcand_d = b_mag;
                acc_d   = {{W{1'b0}}, a_mag};
            end
        end else if (state_q == S_RUN) begin
            acc_d   = step;
            cnt_d   = cnt_q + 1'b1;
            state_d = cnt_q == CNT_W'(W - 1) ? S_FINISH : S_RUN;
        end else begin
            hi_d    = hi_res;
            lo_d    = lo_res;
            done_d  = 1'b1;
            state_d = S_IDLE;
        end
`ifdef MULDIV_ABORT_EN
        if (state_q != S_IDLE && bus.abort) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            div0_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            a_org_q <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            div0_q  <= div0_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            a_org_q <= a_org_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.busy = state_q != S_IDLE;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of muldiv_unit timing, arithmetic, MTHI/MTLO and reset.
// With MULDIV_ABORT_EN defined the abort flush is exercised as well.
module tb_muldiv_unit;
    import muldiv_pkg::*;
    logic clk = 1'b0;
    logic rst_n;
    int n_run = 0;
    int n_fail = 0;
    int k;
    int seen;

    muldiv_if #(.WIDTH(32)) bus ();
    muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input op_e op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic mtx(input logic h, input logic l, input logic [31:0] d);
        bus.hi_we = h;
        bus.lo_we = l;
        bus.wdata = d;
        @(posedge clk);
        #1 bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
    endtask

    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1 if (bus.done) cnt++;
        end
    endtask

    task automatic run(input string tag, input op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cyc;
        issue(op, a, b);
        chk({tag, " busy_after_start"}, 64'(bus.busy), 64'd1);
        wait_done(cyc);
        chk({tag, " latency"}, 64'(cyc), 64'd33);
        chk({tag, " hi"}, 64'(bus.hi), 64'(exp_hi));
        chk({tag, " lo"}, 64'(bus.lo), 64'(exp_lo));
        chk({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1 chk({tag, " done_one_cycle"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = OP_MULT;
        bus.a     = '0;
        bus.b     = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;
`ifdef MULDIV_ABORT_EN
        bus.abort = 1'b0;
`endif
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #20;
        chk("rst busy", 64'(bus.busy), 64'd0);
        chk("rst done", 64'(bus.done), 64'd0);
        chk("rst hi", 64'(bus.hi), 64'd0);
        chk("rst lo", 64'(bus.lo), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        run("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run("divu", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        run("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        run("divu_zero", OP_DIVU, 32'd100, 32'd0, 32'h64, 32'hFFFF_FFFF);
        run("div_zero", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
        run("mult_negneg", OP_MULT, 32'hFFFF_FFFA, 32'hFFFF_FFFC, 32'h0, 32'd24);
        run("div_negden", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);

        mtx(1'b1, 1'b0, 32'h0000_1234);
        mtx(1'b0, 1'b1, 32'h0000_5678);
        chk("mthi", 64'(bus.hi), 64'h1234);
        chk("mtlo", 64'(bus.lo), 64'h5678);

        issue(OP_MULT, 32'd5, 32'd6);
        repeat (9) @(posedge clk);
        #1 bus.start = 1'b1;
        bus.op    = OP_MULTU;
        bus.a     = 32'd1;
        bus.b     = 32'd1;
        bus.hi_we = 1'b1;
        bus.wdata = 32'h0000_FFFF;
        @(posedge clk);
        #1 bus.start = 1'b0;
        bus.hi_we = 1'b0;
        chk("busy_ign busy", 64'(bus.busy), 64'd1);
        chk("busy_ign hi_held", 64'(bus.hi), 64'h1234);
        wait_done(k);
        chk("busy_ign latency", 64'(k), 64'd23);
        chk("busy_ign hi", 64'(bus.hi), 64'd0);
        chk("busy_ign lo", 64'(bus.lo), 64'd30);
        @(posedge clk);
        #1 chk("busy_ign no_queue", 64'(bus.busy), 64'd0);

        issue(OP_MULT, 32'd3, 32'd4);
        wait_done(k);
        chk("b2b first_lo", 64'(bus.lo), 64'd12);
        issue(OP_DIVU, 32'd9, 32'd2);
        chk("b2b busy", 64'(bus.busy), 64'd1);
        wait_done(k);
        chk("b2b latency", 64'(k), 64'd33);
        chk("b2b hi", 64'(bus.hi), 64'd1);
        chk("b2b lo", 64'(bus.lo), 64'd4);
        @(posedge clk);
        #1;

        bus.hi_we = 1'b1;
        bus.wdata = 32'h0000_AAAA;
        issue(OP_MULTU, 32'd2, 32'd3);
        bus.hi_we = 1'b0;
        chk("we_start hi_written", 64'(bus.hi), 64'hAAAA);
        wait_done(k);
        chk("we_start hi", 64'(bus.hi), 64'd0);
        chk("we_start lo", 64'(bus.lo), 64'd6);
        @(posedge clk);
        #1;

`ifdef MULDIV_ABORT_EN
        mtx(1'b1, 1'b1, 32'h0000_BEEF);
        issue(OP_MULT, 32'd2, 32'd3);
        repeat (14) @(posedge clk);
        #1 bus.abort = 1'b1;
        @(posedge clk);
        #1 bus.abort = 1'b0;
        chk("abort busy", 64'(bus.busy), 64'd0);
        chk("abort hi", 64'(bus.hi), 64'hBEEF);
        chk("abort lo", 64'(bus.lo), 64'hBEEF);
        count_done(40, seen);
        chk("abort no_done", 64'(seen), 64'd0);
        bus.abort = 1'b1;
        issue(OP_MULTU, 32'd7, 32'd8);
        bus.abort = 1'b0;
        chk("abort_idle start_wins", 64'(bus.busy), 64'd1);
        wait_done(k);
        chk("abort_idle lo", 64'(bus.lo), 64'd56);
        @(posedge clk);
        #1;
`endif

        mtx(1'b1, 1'b1, 32'h0000_DEAD);
        issue(OP_MULT, 32'd2, 32'd3);
        repeat (14) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst busy", 64'(bus.busy), 64'd0);
        chk("midrst hi", 64'(bus.hi), 64'd0);
        chk("midrst lo", 64'(bus.lo), 64'd0);
        chk("midrst done", 64'(bus.done), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        count_done(40, seen);
        chk("midrst no_done", 64'(seen), 64'd0);
        chk("midrst lo_after", 64'(bus.lo), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
